// File: rtl/piccolo_dec.sv
// piccolo_dec: iterative Piccolo-80/128 block decryptor, one round per clock.
// Built from the same F and RP datapath as the encryptor. It uses the
// decryption whitening keys and walks the forward round keys in reverse order.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high
//   start      - load request, sampled only in IDLE or DONE
//   version    - 0 = Piccolo-80 (key[127:48]), 1 = Piccolo-128; sampled with start
//   key        - master key; spec bit 0 is key[127] (MSB-first)
//   ciphertext - 64-bit block; spec bit 0 is ciphertext[63]
//   plaintext  - result, valid while done = 1
//   busy       - high from the accept edge until DONE
//   done       - level, high in DONE, cleared by the next accepted start
module piccolo_dec #(
  parameter int R80  = 25,
  parameter int R128 = 31
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         version,
  input  logic [127:0] key,
  input  logic [63:0]  ciphertext,
  output logic [63:0]  plaintext,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PREP  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [4:0]  LAST80    = 5'(R80 - 1);
  localparam logic [4:0]  LAST128   = 5'(R128 - 1);
  localparam logic [31:0] CON80_XOR  = 32'h0f1e2d3c;
  localparam logic [31:0] CON128_XOR = 32'h6547a98b;

  // 4-bit Piccolo S-box
  function automatic logic [3:0] sbox(input logic [3:0] a);
    logic [3:0] y;
    case (a)
      4'h0: y = 4'he;  4'h1: y = 4'h4;  4'h2: y = 4'hb;  4'h3: y = 4'h2;
      4'h4: y = 4'h3;  4'h5: y = 4'h8;  4'h6: y = 4'h0;  4'h7: y = 4'h9;
      4'h8: y = 4'h1;  4'h9: y = 4'ha;  4'ha: y = 4'h7;  4'hb: y = 4'hf;
      4'hc: y = 4'h6;  4'hd: y = 4'hc;  4'he: y = 4'h5;  4'hf: y = 4'hd;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // Multiply by x in GF(2^4) modulo x^4 + x + 1
  function automatic logic [3:0] gm2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  // F: S-box layer, diffusion matrix M, S-box layer
  function automatic logic [15:0] f_fn(input logic [15:0] x);
    logic [3:0] a0, a1, a2, a3, y0, y1, y2, y3;
    a0 = sbox(x[15:12]);
    a1 = sbox(x[11:8]);
    a2 = sbox(x[7:4]);
    a3 = sbox(x[3:0]);
    y0 = gm2(a0) ^ gm2(a1) ^ a1 ^ a2 ^ a3;
    y1 = a0 ^ gm2(a1) ^ gm2(a2) ^ a2 ^ a3;
    y2 = a0 ^ a1 ^ gm2(a2) ^ gm2(a3) ^ a3;
    y3 = gm2(a0) ^ a0 ^ a1 ^ a2 ^ gm2(a3);
    return {sbox(y0), sbox(y1), sbox(y2), sbox(y3)};
  endfunction

  // RP byte permutation: (x0..x7) <- (x2,x7,x4,x1,x6,x3,x0,x5)
  function automatic logic [63:0] rp_fn(input logic [63:0] x);
    return {x[47:40], x[7:0], x[31:24], x[55:48], x[15:8], x[39:32], x[63:56], x[23:16]};
  endfunction

  // Forward 128-bit key permutation P: (k0..k7) <- (k2,k1,k6,k7,k0,k3,k4,k5)
  function automatic logic [127:0] perm_p(input logic [127:0] k);
    return {k[95:80], k[111:96], k[31:16], k[15:0], k[127:112], k[79:64], k[63:48], k[47:32]};
  endfunction

  // Inverse permutation P^-1: (k0..k7) <- (k4,k1,k0,k5,k6,k7,k2,k3)
  function automatic logic [127:0] perm_pinv(input logic [127:0] k);
    return {k[63:48], k[111:96], k[127:112], k[47:32], k[31:16], k[15:0], k[95:80], k[79:64]};
  endfunction

  // Select 16-bit key word idx (word 0 is the most significant)
  function automatic logic [15:0] key_word(input logic [127:0] k, input logic [2:0] idx);
    logic [15:0] w;
    case (idx)
      3'd0: w = k[127:112];
      3'd1: w = k[111:96];
      3'd2: w = k[95:80];
      3'd3: w = k[79:64];
      3'd4: w = k[63:48];
      3'd5: w = k[47:32];
      3'd6: w = k[31:16];
      3'd7: w = k[15:0];
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  state_t         state_r;
  logic [63:0]    x_r;
  logic [127:0]   key_r;
  logic           ver_r;
  logic [4:0]     ctr_r;
  logic [2:0]     prep_r;

  logic [15:0]    wk2_in_s, wk3_in_s;
  logic [15:0]    wk0_s, wk1_s;
  logic [4:0]     last_s, p_s, pp1_s, pmod5_s;
  logic [31:0]    con_s;
  logic [15:0]    ka_s, kb_s, rka_s, rkb_s, rk0_s, rk1_s;
  logic [15:0]    x1n_s, x3n_s;
  logic [63:0]    mixed_s;

  // Input whitening keys wk2/wk3 taken straight from the key port for the accept cycle
  always_comb begin
    wk2_in_s = 16'h0000;
    wk3_in_s = 16'h0000;
    if (version) begin
      wk2_in_s = {key[63:56], key[7:0]};
      wk3_in_s = {key[15:8], key[55:48]};
    end else begin
      wk2_in_s = {key[63:56], key[71:64]};
      wk3_in_s = {key[79:72], key[55:48]};
    end
  end

  // Final whitening keys wk0/wk1; the 128-bit key register is back to the original words by the last round
  always_comb begin
    wk0_s = {key_r[127:120], key_r[103:96]};
    wk1_s = {key_r[111:104], key_r[119:112]};
  end

  // Round datapath: reverse-order round key pair, F mixing, RP
  always_comb begin
    last_s  = ver_r ? LAST128 : LAST80;
    p_s     = last_s - ctr_r;
    pp1_s   = p_s + 5'd1;
    pmod5_s = p_s % 5'd5;
    con_s   = {pp1_s, 5'd0, pp1_s, 2'b00, pp1_s, 5'd0, pp1_s} ^ (ver_r ? CON128_XOR : CON80_XOR);
    ka_s    = 16'h0000;
    kb_s    = 16'h0000;
    if (ver_r) begin
      // forward rk_j uses word (j+2) mod 8, i.e. 2*((p+1) mod 4) and its neighbour
      ka_s = key_word(key_r, {pp1_s[1:0], 1'b0});
      kb_s = key_word(key_r, {pp1_s[1:0], 1'b1});
    end else begin
      case (pmod5_s)
        5'd0, 5'd2: begin
          ka_s = key_r[95:80];
          kb_s = key_r[79:64];
        end
        5'd1, 5'd4: begin
          ka_s = key_r[127:112];
          kb_s = key_r[111:96];
        end
        5'd3: begin
          ka_s = key_r[63:48];
          kb_s = key_r[63:48];
        end
        default: begin
          ka_s = 16'h0000;
          kb_s = 16'h0000;
        end
      endcase
    end
    rka_s = con_s[31:16] ^ ka_s;
    rkb_s = con_s[15:0] ^ kb_s;
    // the RP of the encryptor swaps the left/right halves on odd decryption rounds
    if (ctr_r[0]) begin
      rk0_s = rkb_s;
      rk1_s = rka_s;
    end else begin
      rk0_s = rka_s;
      rk1_s = rkb_s;
    end
    x1n_s   = x_r[47:32] ^ f_fn(x_r[63:48]) ^ rk0_s;
    x3n_s   = x_r[15:0] ^ f_fn(x_r[31:16]) ^ rk1_s;
    mixed_s = {x_r[63:48], x1n_s, x_r[31:16], x3n_s};
  end

  // Control FSM with datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      x_r       <= 64'h0;
      key_r     <= 128'h0;
      ver_r     <= 1'b0;
      ctr_r     <= 5'd0;
      prep_r    <= 3'd0;
      plaintext <= 64'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            key_r   <= key;
            ver_r   <= version;
            x_r     <= ciphertext ^ {wk2_in_s, 16'h0000, wk3_in_s, 16'h0000};
            ctr_r   <= 5'd0;
            prep_r  <= 3'd0;
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= version ? ST_PREP : ST_ROUND;
          end
        end
        ST_PREP: begin
          // advance the key register to the state the encryptor ends in (P applied 7 times)
          key_r  <= perm_p(key_r);
          prep_r <= prep_r + 3'd1;
          if (prep_r == 3'd6) begin
            state_r <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (ver_r && (p_s[1:0] == 2'b11)) begin
            key_r <= perm_pinv(key_r);
          end
          if (ctr_r == last_s) begin
            plaintext <= {x_r[63:48] ^ wk0_s, x1n_s, x_r[31:16] ^ wk1_s, x3n_s};
            busy      <= 1'b0;
            done      <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            x_r   <= rp_fn(mixed_s);
            ctr_r <= ctr_r + 5'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piccolo_dec.sv
// Testbench for piccolo_dec. A behavioural Piccolo encryptor produces
// ciphertexts. A scoreboard queue holds the expected plaintext and the edge on
// which done is expected. A monitor checks every rising edge of done against it.
module tb_piccolo_dec;

  logic         clk;
  logic         reset;
  logic         start;
  logic         version;
  logic [127:0] key;
  logic [63:0]  ciphertext;
  logic [63:0]  plaintext;
  logic         busy;
  logic         done;

  piccolo_dec dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .version    (version),
    .key        (key),
    .ciphertext (ciphertext),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [63:0] pt;
    int          done_edge;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_n   = 0;
  logic done_prev = 1'b0;

  localparam logic [127:0] K80  = {80'h00112233445566778899, 48'h0};
  localparam logic [127:0] K128 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [63:0]  PT0  = 64'h0123456789abcdef;
  localparam logic [63:0]  CT80 = 64'h8d2bff9935f84056;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- reference encryptor ----------------
  function automatic logic [3:0] m_sbox(input logic [3:0] a);
    logic [63:0] tbl;
    tbl = 64'he4b238091a7f6c5d;
    return tbl[63 - 4*a -: 4];
  endfunction

  function automatic logic [3:0] m_gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [15:0] m_f(input logic [15:0] x);
    logic [15:0] mrow [4];
    logic [3:0]  a [4];
    logic [3:0]  y;
    logic [15:0] out;
    mrow = '{16'h2311, 16'h1231, 16'h1123, 16'h3112};
    for (int i = 0; i < 4; i++) a[i] = m_sbox(x[15 - 4*i -: 4]);
    out = 16'h0;
    for (int r = 0; r < 4; r++) begin
      y = 4'h0;
      for (int c = 0; c < 4; c++) y = y ^ m_gmul(mrow[r][15 - 4*c -: 4], a[c]);
      out[15 - 4*r -: 4] = m_sbox(y);
    end
    return out;
  endfunction

  function automatic logic [63:0] m_rp(input logic [63:0] x);
    logic [31:0] perm;
    logic [63:0] o;
    perm = 32'h27416305;
    for (int i = 0; i < 8; i++) o[63 - 8*i -: 8] = x[63 - 8*perm[31 - 4*i -: 4] -: 8];
    return o;
  endfunction

  function automatic logic [63:0] m_enc(input logic v, input logic [127:0] kin, input logic [63:0] pt);
    logic [15:0] k [8];
    logic [15:0] t [8];
    logic [15:0] rk [62];
    logic [15:0] wk0, wk1, wk2, wk3, x0, x1, x2, x3;
    logic [31:0] con;
    logic [4:0]  c;
    int          r, j;
    for (int i = 0; i < 8; i++) k[i] = kin[127 - 16*i -: 16];
    wk0 = {k[0][15:8], k[1][7:0]};
    wk1 = {k[1][15:8], k[0][7:0]};
    if (v) begin
      wk2 = {k[4][15:8], k[7][7:0]};
      wk3 = {k[7][15:8], k[4][7:0]};
    end else begin
      wk2 = {k[4][15:8], k[3][7:0]};
      wk3 = {k[3][15:8], k[4][7:0]};
    end
    r = v ? 31 : 25;
    for (int i = 0; i < r; i++) begin
      c   = 5'(i + 1);
      con = {c, 5'd0, c, 2'b00, c, 5'd0, c} ^ (v ? 32'h6547a98b : 32'h0f1e2d3c);
      if (!v) begin
        case (i % 5)
          0, 2: begin rk[2*i] = con[31:16] ^ k[2]; rk[2*i+1] = con[15:0] ^ k[3]; end
          1, 4: begin rk[2*i] = con[31:16] ^ k[0]; rk[2*i+1] = con[15:0] ^ k[1]; end
          default: begin rk[2*i] = con[31:16] ^ k[4]; rk[2*i+1] = con[15:0] ^ k[4]; end
        endcase
      end else begin
        for (int h = 0; h < 2; h++) begin
          j = 2*i + h;
          if ((j + 2) % 8 == 0) begin
            t = k;
            k = '{t[2], t[1], t[6], t[7], t[0], t[3], t[4], t[5]};
          end
          rk[j] = k[(j + 2) % 8] ^ ((h == 0) ? con[31:16] : con[15:0]);
        end
      end
    end
    x0 = pt[63:48] ^ wk0; x1 = pt[47:32]; x2 = pt[31:16] ^ wk1; x3 = pt[15:0];
    for (int i = 0; i < r; i++) begin
      x1 = x1 ^ m_f(x0) ^ rk[2*i];
      x3 = x3 ^ m_f(x2) ^ rk[2*i+1];
      if (i != r - 1) {x0, x1, x2, x3} = m_rp({x0, x1, x2, x3});
    end
    return {x0 ^ wk2, x1, x2 ^ wk3, x3};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Monitor: every rising edge of done is matched against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: plaintext %h with nothing expected (edge %0d)", plaintext, edge_n);
        end else begin
          e = q.pop_front();
          chk("plaintext", plaintext, e.pt);
          chk("latency_edge", 64'(edge_n), 64'(e.done_edge));
        end
      end
      done_prev = done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_start(input logic v, input logic [127:0] k, input logic [63:0] c,
                             input logic [63:0] exp_pt, input bit push);
    @(negedge clk);
    version = v; key = k; ciphertext = c; start = 1'b1;
    @(posedge clk); #1;
    if (push) q.push_back('{exp_pt, edge_n + (v ? 39 : 26) - 1});
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: done still %b, expected 1 within 100 cycles", name, done);
    end
  endtask

  initial begin
    logic [127:0] rk;
    logic [63:0]  rp, rc;
    logic         rv;
    bit           seen;

    reset = 1'b1; start = 1'b1; version = 1'b0; key = K80; ciphertext = CT80;
    repeat (3) @(posedge clk);
    #1;
    // reset wins over start
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_plaintext", plaintext, 64'h0);
    @(negedge clk);
    start = 1'b0; reset = 1'b0;

    // the reference model must reproduce the published Piccolo-80 vector
    chk("model_vector80", m_enc(1'b0, K80, PT0), CT80);

    // directed vectors
    drive_start(1'b0, K80, CT80, PT0, 1'b1);
    wait_done("v80");
    drive_start(1'b1, K128, m_enc(1'b1, K128, PT0), PT0, 1'b1);
    wait_done("v128");
    drive_start(1'b0, 128'h0, m_enc(1'b0, 128'h0, 64'h0), 64'h0, 1'b1);
    wait_done("zero80");
    drive_start(1'b1, {128{1'b1}}, m_enc(1'b1, {128{1'b1}}, {64{1'b1}}), {64{1'b1}}, 1'b1);
    wait_done("ones128");

    // start held high for the whole run while key and ciphertext change
    @(negedge clk);
    version = 1'b1; key = K128; ciphertext = m_enc(1'b1, K128, 64'hfedcba9876543210); start = 1'b1;
    @(posedge clk); #1;
    q.push_back('{64'hfedcba9876543210, edge_n + 38});
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else begin
        key = {$urandom, $urandom, $urandom, $urandom};
        ciphertext = {$urandom, $urandom};
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL timeout_hold: done still %b, expected 1", done);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("hold_done_stays", 64'(done), 64'd1);
    chk("hold_busy_low", 64'(busy), 64'd0);

    // reset during round 10 aborts with no output
    drive_start(1'b0, K80, CT80, PT0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("busy_before_abort", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_plaintext", plaintext, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    drive_start(1'b0, K80, CT80, PT0, 1'b1);
    wait_done("after_abort");

    // back-to-back: new start while in DONE
    drive_start(1'b1, K128, m_enc(1'b1, K128, 64'h55aa55aa0ff0f00f), 64'h55aa55aa0ff0f00f, 1'b1);
    chk("b2b_done_drops", 64'(done), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done("b2b");

    // random round trips
    for (int n = 0; n < 300; n++) begin
      rv = 1'($urandom_range(0, 1));
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom};
      rc = m_enc(rv, rk, rp);
      drive_start(rv, rk, rc, rp, 1'b1);
      wait_done("random");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
